// File: rtl/project.sv
// IEEE 1149.1 TAP controller with BYPASS, USERDATA and optional IDCODE data registers.
// Optional feature macro: PROJECT_IDCODE_EN adds the 32-bit IDCODE register/decode and
// makes IDCODE the reset instruction (BYPASS otherwise).
module project #(
  parameter int unsigned IR_LEN     = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1234_5679,
  parameter int unsigned UDR_LEN    = 8
) (
  input  logic TCK,
  input  logic TRST,
  input  logic TMS,
  input  logic TDI,
  output logic TDO
);

  localparam logic [IR_LEN-1:0] IR_CAPTURE = IR_LEN'(4'b0101);
  localparam logic [IR_LEN-1:0] IR_BYPASS  = IR_LEN'(4'b1111);
  localparam logic [IR_LEN-1:0] IR_USER    = IR_LEN'(4'b0010);
`ifdef PROJECT_IDCODE_EN
  localparam logic [IR_LEN-1:0] IR_IDCODE  = IR_LEN'(4'b0001);
  localparam logic [IR_LEN-1:0] IR_RESET   = IR_IDCODE;
`else
  localparam logic [IR_LEN-1:0] IR_RESET   = IR_BYPASS;
`endif

  // IDCODE_VAL must carry the mandatory 1 in bit 0
  if (IDCODE_VAL[0] != 1'b1) begin : g_idcode_lsb_check
    $error("IDCODE_VAL bit 0 must be 1");
  end

  typedef enum logic [3:0] {
    TEST_LOGIC_RESET,
    RUN_TEST_IDLE,
    SELECT_DR_SCAN,
    CAPTURE_DR,
    SHIFT_DR,
    EXIT1_DR,
    PAUSE_DR,
    EXIT2_DR,
    UPDATE_DR,
    SELECT_IR_SCAN,
    CAPTURE_IR,
    SHIFT_IR,
    EXIT1_IR,
    PAUSE_IR,
    EXIT2_IR,
    UPDATE_IR
  } tap_state_t;

  tap_state_t         state;
  logic [IR_LEN-1:0]  ir_sr;
  logic [IR_LEN-1:0]  ir;
  logic               bypass_sr;
  logic [UDR_LEN-1:0] udr_sr;
  logic [UDR_LEN-1:0] udr_hold;
  logic               sel_user_c;
  logic               dr_tdo_c;
`ifdef PROJECT_IDCODE_EN
  logic [31:0]        idcode_sr;
  logic               sel_idcode_c;
`endif

  // TAP state machine: standard TMS transition table
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state <= TEST_LOGIC_RESET;
    end else begin
      case (state)
        TEST_LOGIC_RESET: state <= TMS ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
        RUN_TEST_IDLE:    state <= TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_DR_SCAN:   state <= TMS ? SELECT_IR_SCAN   : CAPTURE_DR;
        CAPTURE_DR:       state <= TMS ? EXIT1_DR         : SHIFT_DR;
        SHIFT_DR:         state <= TMS ? EXIT1_DR         : SHIFT_DR;
        EXIT1_DR:         state <= TMS ? UPDATE_DR        : PAUSE_DR;
        PAUSE_DR:         state <= TMS ? EXIT2_DR         : PAUSE_DR;
        EXIT2_DR:         state <= TMS ? UPDATE_DR        : SHIFT_DR;
        UPDATE_DR:        state <= TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        SELECT_IR_SCAN:   state <= TMS ? TEST_LOGIC_RESET : CAPTURE_IR;
        CAPTURE_IR:       state <= TMS ? EXIT1_IR         : SHIFT_IR;
        SHIFT_IR:         state <= TMS ? EXIT1_IR         : SHIFT_IR;
        EXIT1_IR:         state <= TMS ? UPDATE_IR        : PAUSE_IR;
        PAUSE_IR:         state <= TMS ? EXIT2_IR         : PAUSE_IR;
        EXIT2_IR:         state <= TMS ? UPDATE_IR        : SHIFT_IR;
        UPDATE_IR:        state <= TMS ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
        default:          state <= TEST_LOGIC_RESET;
      endcase
    end
  end

  // Instruction decode; unknown codes fall through to BYPASS
  always_comb begin
    sel_user_c = (ir == IR_USER);
`ifdef PROJECT_IDCODE_EN
    sel_idcode_c = (ir == IR_IDCODE);
`endif
  end

  // Serial output of the selected data register
  always_comb begin
    dr_tdo_c = bypass_sr;
    if (sel_user_c) begin
      dr_tdo_c = udr_sr[0];
    end
`ifdef PROJECT_IDCODE_EN
    else if (sel_idcode_c) begin
      dr_tdo_c = idcode_sr[0];
    end
`endif
  end

  // IR shift register: capture fixed pattern, shift right with TDI into MSB
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sr <= '0;
    end else if (state == CAPTURE_IR) begin
      ir_sr <= IR_CAPTURE;
    end else if (state == SHIFT_IR) begin
      ir_sr <= {TDI, ir_sr[IR_LEN-1:1]};
    end
  end

  // Data shift registers: capture and shift only the selected one
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bypass_sr <= 1'b0;
      udr_sr    <= '0;
`ifdef PROJECT_IDCODE_EN
      idcode_sr <= '0;
`endif
    end else if (state == CAPTURE_DR) begin
      if (sel_user_c) begin
        udr_sr <= udr_hold;
      end
`ifdef PROJECT_IDCODE_EN
      else if (sel_idcode_c) begin
        idcode_sr <= IDCODE_VAL;
      end
`endif
      else begin
        bypass_sr <= 1'b0;
      end
    end else if (state == SHIFT_DR) begin
      if (sel_user_c) begin
        udr_sr <= {TDI, udr_sr[UDR_LEN-1:1]};
      end
`ifdef PROJECT_IDCODE_EN
      else if (sel_idcode_c) begin
        idcode_sr <= {TDI, idcode_sr[31:1]};
      end
`endif
      else begin
        bypass_sr <= TDI;
      end
    end
  end

  // Falling-edge updates: active instruction and user holding register
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir       <= IR_RESET;
      udr_hold <= '0;
    end else begin
      if (state == TEST_LOGIC_RESET) begin
        ir <= IR_RESET;
      end else if (state == UPDATE_IR) begin
        ir <= ir_sr;
      end
      if (state == UPDATE_DR && sel_user_c) begin
        udr_hold <= udr_sr;
      end
    end
  end

  // TDO launched on the falling edge, driven only while shifting
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      TDO <= 1'b0;
    end else if (state == SHIFT_IR) begin
      TDO <= ir_sr[0];
    end else if (state == SHIFT_DR) begin
      TDO <= dr_tdo_c;
    end else begin
      TDO <= 1'b0;
    end
  end

endmodule

// File: tb/tb_project.sv
// Testbench for project: queue-based TAP model with per-cycle TDO comparison,
// directed literal scans and randomized TMS/TDI traffic.
module tb_project;

  logic TCK = 1'b0;
  logic TRST;
  logic TMS = 1'b0;
  logic TDI = 1'b0;
  logic TDO;

  project dut (
    .TCK  (TCK),
    .TRST (TRST),
    .TMS  (TMS),
    .TDI  (TDI),
    .TDO  (TDO)
  );

  always #5 TCK = ~TCK;

  localparam int S_TLR = 0, S_RTI = 1, S_SDS = 2, S_CDR = 3, S_SHDR = 4, S_E1DR = 5,
                 S_PDR = 6, S_E2DR = 7, S_UDR = 8, S_SIS = 9, S_CIR = 10, S_SHIR = 11,
                 S_E1IR = 12, S_PIR = 13, S_E2IR = 14, S_UIR = 15;
  localparam logic [31:0] IDV = 32'h1234_5679;
`ifdef PROJECT_IDCODE_EN
  localparam logic [3:0] RST_INSTR = 4'b0001;
`else
  localparam logic [3:0] RST_INSTR = 4'b1111;
`endif

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model: registers are queues of bits, front = LSB = next bit out
  int         m_st;
  logic [3:0] m_ir;
  logic [7:0] m_hold;
  bit         irq[$];
  bit         drq[$];
  bit         m_tdo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int nxt(input int s, input bit t);
    case (s)
      S_TLR:  return t ? S_TLR  : S_RTI;
      S_RTI:  return t ? S_SDS  : S_RTI;
      S_SDS:  return t ? S_SIS  : S_CDR;
      S_CDR:  return t ? S_E1DR : S_SHDR;
      S_SHDR: return t ? S_E1DR : S_SHDR;
      S_E1DR: return t ? S_UDR  : S_PDR;
      S_PDR:  return t ? S_E2DR : S_PDR;
      S_E2DR: return t ? S_UDR  : S_SHDR;
      S_UDR:  return t ? S_SDS  : S_RTI;
      S_SIS:  return t ? S_TLR  : S_CIR;
      S_CIR:  return t ? S_E1IR : S_SHIR;
      S_SHIR: return t ? S_E1IR : S_SHIR;
      S_E1IR: return t ? S_UIR  : S_PIR;
      S_PIR:  return t ? S_E2IR : S_PIR;
      S_E2IR: return t ? S_UIR  : S_SHIR;
      default: return t ? S_SDS : S_RTI;
    endcase
  endfunction

  function automatic logic [63:0] qval(input bit q[$]);
    logic [63:0] v = '0;
    foreach (q[i]) v[i] = q[i];
    return v;
  endfunction

  function automatic bit is_user();
    return m_ir == 4'b0010;
  endfunction

  function automatic bit is_idcode();
`ifdef PROJECT_IDCODE_EN
    return m_ir == 4'b0001;
`else
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_st = S_TLR; m_ir = RST_INSTR; m_hold = '0; m_tdo = 1'b0;
    irq.delete(); drq.delete();
    for (int i = 0; i < 4; i++) irq.push_back(1'b0);
    drq.push_back(1'b0);
  endtask

  task automatic m_pos(input bit t, input bit d);
    logic [3:0] cap = 4'b0101;
    case (m_st)
      S_CIR: begin
        irq.delete();
        for (int i = 0; i < 4; i++) irq.push_back(cap[i]);
      end
      S_SHIR: begin void'(irq.pop_front()); irq.push_back(d); end
      S_CDR: begin
        drq.delete();
        if (is_user()) for (int i = 0; i < 8; i++) drq.push_back(m_hold[i]);
        else if (is_idcode()) for (int i = 0; i < 32; i++) drq.push_back(IDV[i]);
        else drq.push_back(1'b0);
      end
      S_SHDR: begin void'(drq.pop_front()); drq.push_back(d); end
      default: ;
    endcase
    m_st = nxt(m_st, t);
  endtask

  task automatic m_neg();
    logic [63:0] v;
    if (m_st == S_TLR) m_ir = RST_INSTR;
    if (m_st == S_UIR) begin v = qval(irq); m_ir = v[3:0]; end
    if (m_st == S_UDR && is_user()) begin v = qval(drq); m_hold = v[7:0]; end
    m_tdo = (m_st == S_SHIR) ? irq[0] : (m_st == S_SHDR) ? drq[0] : 1'b0;
  endtask

  // single compare process: TDO vs model, once per cycle after the falling edge
  always begin
    @(negedge TCK);
    #3;
    if (chk_en) chk("tdo_vs_model", 64'(TDO), 64'(m_tdo));
  end

  // one TCK cycle; o = TDO after the following falling edge
  task automatic tick(input bit t, input bit d, output bit o);
    TMS = t; TDI = d;
    @(posedge TCK);
    m_pos(t, d);
    @(negedge TCK);
    m_neg();
    #3;
    o = TDO;
  endtask

  task automatic apply_reset();
    #1;
    TRST = 1'b0;
    m_reset();
    repeat (2) @(negedge TCK);
    #1;
    TRST = 1'b1;
  endtask

  task automatic goto_tlr();
    bit o;
    repeat (5) tick(1'b1, 1'($urandom), o);
  endtask

  // from Run-Test/Idle: load code, return to Run-Test/Idle; outs = first 4 TDO bits
  task automatic scan_ir(input logic [3:0] code, output logic [3:0] outs);
    bit o;
    tick(1, 0, o); tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
    outs[0] = o;
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, code[i], o);
      if (i < 3) outs[i+1] = o;
    end
    tick(1, 0, o); tick(0, 0, o);
  endtask

  // from Run-Test/Idle: shift n bits of din, optional pauses; dout = bits seen on TDO
  task automatic scan_dr(input int n, input logic [63:0] din, input bit pause_en,
                         output logic [63:0] dout);
    bit o;
    dout = '0;
    tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
    dout[0] = o;
    for (int i = 0; i < n; i++) begin
      if (i != n - 1 && pause_en && ($urandom % 4 == 0)) begin
        tick(1, din[i], o);
        repeat ($urandom_range(1, 3)) tick(0, 1'($urandom), o);
        tick(1, 0, o);
        tick(0, 0, o);
        dout[i+1] = o;
      end else begin
        tick(i == n - 1, din[i], o);
        if (i != n - 1) dout[i+1] = o;
      end
    end
    tick(1, 0, o); tick(0, 0, o);
  endtask

  initial begin
    bit o;
    logic [3:0]  ir_out;
    logic [63:0] d;
    logic [3:0]  codes [4];
    int r;

    TRST = 1'b0;
    apply_reset();
    chk_en = 1'b1;
    chk("reset_tdo", 64'(TDO), 64'd0);

    // reset then one TMS=0 cycle: Run-Test/Idle, TDO low
    tick(0, 1, o);
    chk("rti_tdo", 64'(o), 64'd0);

    // reset instruction selects expected data register
    scan_dr(32, 64'h0, 0, d);
`ifdef PROJECT_IDCODE_EN
    chk("idcode_scan", d[31:0], 64'h1234_5679);
`else
    chk("reset_bypass_scan", d[31:0], 64'd0);
`endif

    // random wander, then five TMS=1 must land in Test-Logic-Reset
    repeat (7) tick(1'($urandom), 1'($urandom), o);
    goto_tlr();
    tick(0, 0, o);
    scan_ir(4'b0000, ir_out);
    chk("ir_capture", 64'(ir_out), 64'b0101);

    // BYPASS: captured 0 then TDI delayed one cycle
    scan_ir(4'b1111, ir_out);
    scan_dr(4, 64'b1101, 0, d);
    chk("bypass_seq", d[3:0], 64'b1010);

    // code 0001 without the IDCODE feature, and an undefined code, act as BYPASS
`ifndef PROJECT_IDCODE_EN
    scan_ir(4'b0001, ir_out);
    scan_dr(4, 64'b0110, 0, d);
    chk("0001_is_bypass", d[3:0], 64'b1100);
`endif
    scan_ir(4'b1010, ir_out);
    scan_dr(3, 64'b111, 1, d);
    chk("undef_is_bypass", d[2:0], 64'b110);

    // USERDATA load, read back, survive TMS reset
    scan_ir(4'b0010, ir_out);
    scan_dr(8, 64'hA5, 0, d);
    chk("user_first_capture", d[7:0], 64'h00);
    scan_dr(8, 64'h3C, 1, d);
    chk("user_readback", d[7:0], 64'hA5);
    goto_tlr();
    tick(0, 0, o);
    scan_ir(4'b0010, ir_out);
    scan_dr(8, 64'h00, 0, d);
    chk("user_after_tms_reset", d[7:0], 64'h3C);

    // TRST mid-shift aborts scan and clears the holding register
    tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
    repeat (3) tick(0, 1, o);
    apply_reset();
    chk("trst_tdo", 64'(TDO), 64'd0);
    tick(0, 0, o);
    scan_ir(4'b0010, ir_out);
    scan_dr(8, 64'h00, 0, d);
    chk("hold_after_trst", d[7:0], 64'h00);

    // randomized traffic, checked by the compare process
    codes[0] = 4'b0001; codes[1] = 4'b0010; codes[2] = 4'b1111; codes[3] = 4'b0000;
    for (int it = 0; it < 80; it++) begin
      r = int'($urandom % 6);
      case (r)
        0, 1: begin
          codes[3] = 4'($urandom);
          scan_ir(codes[$urandom % 4], ir_out);
        end
        2, 3: scan_dr(int'($urandom_range(1, 40)), {$urandom, $urandom}, 1, d);
        4: begin
          repeat ($urandom_range(1, 20)) tick(1'($urandom), 1'($urandom), o);
          goto_tlr();
          tick(0, 0, o);
        end
        default: begin
          tick(1, 0, o); tick(0, 0, o); tick(0, 0, o);
          repeat ($urandom_range(0, 6)) tick(0, 1'($urandom), o);
          apply_reset();
          tick(0, 0, o);
        end
      endcase
    end

    @(negedge TCK);
    #4;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/project.md
PROJECT -- requirements
Module: project

Interface
REQ-001 The module SHALL have parameter IR_LEN, default 4, instruction register length in bits.
REQ-002 The module SHALL have parameter IDCODE_VAL, default 32'h1234_5679, device identification value; bit 0 SHALL be 1.
REQ-003 The module SHALL have parameter UDR_LEN, default 8, user data register length in bits.
REQ-004 The module SHALL have port TCK, input, 1 bit: test clock and the only clock.
REQ-005 The module SHALL have port TRST, input, 1 bit: asynchronous active-low reset.
REQ-006 The module SHALL have port TMS, input, 1 bit: test mode select, sampled on TCK rising edge.
REQ-007 The module SHALL have port TDI, input, 1 bit: serial data in, sampled on TCK rising edge.
REQ-008 The module SHALL have port TDO, output, 1 bit: serial data out, changes on TCK falling edge.

Function
REQ-009 The module SHALL implement the 16-state IEEE 1149.1 TAP controller: Test-Logic-Reset, Run-Test/Idle, Select-DR-Scan, Capture-DR, Shift-DR, Exit1-DR, Pause-DR, Exit2-DR, Update-DR, and the IR equivalents Select-IR-Scan through Update-IR.
REQ-010 The TAP controller SHALL advance on each TCK rising edge using the standard TMS transition table.
REQ-011 Five consecutive TMS=1 rising edges SHALL reach Test-Logic-Reset from any state.
REQ-012 In Capture-IR, the IR shift register SHALL load the constant 4'b0101, with the two LSBs equal to 01.
REQ-013 In Shift-IR, each rising edge SHALL shift the IR shift register right, with TDI entering the MSB.
REQ-014 On the TCK falling edge in Update-IR, the shift contents SHALL be copied into the active instruction register.
REQ-015 The module SHALL decode these instructions: 4'b1111 BYPASS, 4'b0001 IDCODE, 4'b0010 USERDATA; any other code SHALL select BYPASS.
REQ-016 BYPASS SHALL select a 1-bit register that captures 0 in Capture-DR and shifts TDI through in Shift-DR.
REQ-017 IDCODE SHALL select a 32-bit register that loads IDCODE_VAL in Capture-DR and shifts right with TDI into the MSB.
REQ-018 USERDATA SHALL select a UDR_LEN shift register that captures the current user holding register in Capture-DR.
REQ-019 For USERDATA, the shift register SHALL shift right in Shift-DR, and the holding register SHALL be updated from it on the TCK falling edge in Update-DR.
REQ-020 Pause-DR/IR and Exit states SHALL hold shift contents unchanged.
REQ-021 On the TCK falling edge, TDO SHALL present the LSB of the selected shift register when the state is Shift-IR or Shift-DR; otherwise TDO SHALL be 0.
REQ-022 The first bit of a scan SHALL be visible on TDO after the falling edge following entry to Shift; latency SHALL be one half-cycle.
REQ-023 Entering Test-Logic-Reset through TMS SHALL load the reset instruction and SHALL leave the user holding register unchanged.

Reset
REQ-024 While TRST=0, asynchronously: the state SHALL be Test-Logic-Reset, the instruction register SHALL hold the reset instruction, all shift registers and the user holding register SHALL be 0, and TDO SHALL be 0.
REQ-025 The reset instruction SHALL be IDCODE when IDCODE_EN is defined and BYPASS otherwise.
REQ-026 Asserting TRST mid-scan SHALL abort the scan, with no update of the instruction or holding registers.

Configuration
REQ-027 Macro PROJECT_IDCODE_EN: when defined, the IDCODE register and decode SHALL be present.
REQ-028 When PROJECT_IDCODE_EN is undefined, code 4'b0001 SHALL behave as BYPASS, no 32-bit register SHALL exist, and the reset instruction SHALL be BYPASS.

Verification
REQ-029 TRST=0 pulse, then TMS=0 for one cycle -> state Run-Test/Idle, TDO=0.
REQ-030 From any state, apply TMS=1 for 5 edges -> state Test-Logic-Reset.
REQ-031 Shift IR with TDI=0000 -> first 4 TDO bits are 1,0,1,0 (LSB first, capture value 0101).
REQ-032 With PROJECT_IDCODE_EN, after reset go to Shift-DR and shift 32 bits -> TDO sequence is 32'h1234_5679 LSB first.
REQ-033 Load BYPASS, then shift TDI pattern 1,0,1,1 -> TDO is 0,1,0,1 (one-cycle delay after the captured 0).
REQ-034 Load USERDATA, shift in 8'hA5 and pass Update-DR, then rescan -> TDO returns A5 LSB first; then TRST mid-shift -> the holding register reads 0.
